pixel_readout_buffer: RTL and testbench

Downstream stage of the pixel array memory controller: captures one full row of pixel-memory data each time the controller asserts `MEMORY_READ_ENABLE`, holds up to two rows in a ping-pong buffer, and serializes them one pixel per transfer onto a valid/ready output stream toward the chip output interface. It tells the controller to hold off when both buffers are occupied, and flags any row the controller presents while the block is stalled.

---
 rtl/pixel_readout_buffer.sv | 61 ++++++
 tb/tb_pixel_readout_buffer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pixel_readout_buffer.sv
// pixel_readout_buffer: ping-pong row buffer; captures controller rows and serializes pixels onto a valid/ready stream with stall/overflow flags.
module pixel_readout_buffer #(
  parameter int WIDTH = 2,
  parameter int HEIGHT = 2,
  parameter int PIXEL_BITS = 8,
  parameter int ROW_BITS = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  parameter int COL_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                        SYSTEM_CLK,
  input  logic                        SYSTEM_RESET_N,
  input  logic                        MEMORY_READ_ENABLE,
  input  logic [ROW_BITS-1:0]         MEMORY_ROW,
  input  logic [WIDTH*PIXEL_BITS-1:0] DATA_IN,
  output logic                        READ_STALL,
  output logic                        OVERFLOW,
  input  logic                        PIXEL_READY,
  output logic                        PIXEL_VALID,
  output logic [PIXEL_BITS-1:0]       PIXEL_DATA,
  output logic [ROW_BITS-1:0]         PIXEL_ROW,
  output logic [COL_BITS-1:0]         PIXEL_COL,
  output logic                        FRAME_END
);
  logic [WIDTH*PIXEL_BITS-1:0] data_q [2];
  logic [ROW_BITS-1:0] tag_q [2];
  logic wp, rp, last, cap, pop, xfer;
  logic [1:0] count;
  logic [COL_BITS-1:0] col;
  always_comb begin
    PIXEL_VALID = count != 2'd0;
    READ_STALL = count == 2'd2;
    last = col == COL_BITS'(WIDTH - 1);
    xfer = PIXEL_VALID & PIXEL_READY;
    pop = xfer & last;
    cap = MEMORY_READ_ENABLE & ~READ_STALL;
    PIXEL_DATA = PIXEL_VALID ? data_q[rp][col*PIXEL_BITS +: PIXEL_BITS] : '0;
    PIXEL_ROW = PIXEL_VALID ? tag_q[rp] : '0;
    PIXEL_COL = PIXEL_VALID ? col : '0;
    FRAME_END = PIXEL_VALID & (tag_q[rp] == ROW_BITS'(HEIGHT - 1)) & last;
  end
  always_ff @(posedge SYSTEM_CLK) begin
    if (cap) begin
      data_q[wp] <= DATA_IN;
      tag_q[wp] <= MEMORY_ROW;
    end
  end
  always_ff @(posedge SYSTEM_CLK) begin
    if (!SYSTEM_RESET_N) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
      col <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      wp <= wp ^ cap;
      rp <= rp ^ pop;
      count <= count + 2'(cap) - 2'(pop);
      if (xfer) col <= last ? '0 : col + 1'b1;
      if (MEMORY_READ_ENABLE & READ_STALL) OVERFLOW <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pixel_readout_buffer.sv
// tb_pixel_readout_buffer: directed self-checking bench for pixel_readout_buffer (WIDTH=4, HEIGHT=2).
module tb_pixel_readout_buffer;
  logic clk = 1'b0, rst_n, en, ready;
  logic row;
  logic [31:0] din;
  logic stall, ovf, valid, fe;
  logic [7:0] pdata;
  logic prow;
  logic [1:0] pcol;
  int n_chk = 0, n_fail = 0;
  logic [7:0] row_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] row_b [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] row_c [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
  logic [7:0] exp_d;
  logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int idx;
  pixel_readout_buffer #(.WIDTH(4), .HEIGHT(2), .PIXEL_BITS(8)) dut (
    .SYSTEM_CLK(clk), .SYSTEM_RESET_N(rst_n), .MEMORY_READ_ENABLE(en),
    .MEMORY_ROW(row), .DATA_IN(din), .READ_STALL(stall), .OVERFLOW(ovf),
    .PIXEL_READY(ready), .PIXEL_VALID(valid), .PIXEL_DATA(pdata),
    .PIXEL_ROW(prow), .PIXEL_COL(pcol), .FRAME_END(fe)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_pix(input string tag, input logic v, input logic [7:0] d, input logic r, input logic [1:0] c, input logic f);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".data"}, 32'(pdata), 32'(d));
    chk({tag, ".row"}, 32'(prow), 32'(r));
    chk({tag, ".col"}, 32'(pcol), 32'(c));
    chk({tag, ".frame_end"}, 32'(fe), 32'(f));
  endtask
  task automatic capture(input logic r, input logic [31:0] d);
    en = 1'b1;
    row = r;
    din = d;
    tick();
    en = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b0; ready = 1'b0; row = 1'b0; din = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk_pix("reset", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    chk("reset.stall", 32'(stall), 0);
    chk("reset.ovf", 32'(ovf), 0);
    ready = 1'b1;
    capture(1'b0, 32'h44332211);
    for (int i = 0; i < 4; i++) begin
      chk_pix("single", 1'b1, row_a[i], 1'b0, 2'(i), 1'b0);
      tick();
    end
    chk("single.done", 32'(valid), 0);
    ready = 1'b0;
    capture(1'b0, 32'h44332211);
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      ready = pat[i];
      chk_pix("bp", 1'b1, row_a[idx], 1'b0, 2'(idx), 1'b0);
      tick();
      if (pat[i]) idx++;
    end
    chk("bp.count", 32'(idx), 4);
    chk("bp.done", 32'(valid), 0);
    ready = 1'b0;
    capture(1'b0, 32'h44332211);
    chk("fill.stall1", 32'(stall), 0);
    capture(1'b1, 32'h88776655);
    chk("fill.stall", 32'(stall), 1);
    chk("fill.ovf0", 32'(ovf), 0);
    capture(1'b0, 32'hAAAAAAAA);
    chk("ovf.set", 32'(ovf), 1);
    chk("ovf.stall", 32'(stall), 1);
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_d = (k < 4) ? row_a[k] : row_b[k-4];
      chk_pix("drain", 1'b1, exp_d, 1'(k / 4), 2'(k % 4), k == 7);
      chk("drain.stall", 32'(stall), 32'(k < 4));
      tick();
    end
    chk("drain.done", 32'(valid), 0);
    chk("ovf.sticky", 32'(ovf), 1);
    capture(1'b0, 32'h44332211);
    for (int i = 0; i < 4; i++) begin
      chk_pix("simul.a", 1'b1, row_a[i], 1'b0, 2'(i), 1'b0);
      chk("simul.stall", 32'(stall), 0);
      if (i == 3) begin
        en = 1'b1; row = 1'b1; din = 32'h0D0C0B0A;
      end
      tick();
      en = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      chk_pix("simul.b", 1'b1, row_c[i], 1'b1, 2'(i), i == 3);
      chk("simul.stall_b", 32'(stall), 0);
      tick();
    end
    chk("simul.done", 32'(valid), 0);
    capture(1'b1, 32'h44332211);
    tick(); tick();
    chk_pix("midrow", 1'b1, 8'h33, 1'b1, 2'd2, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_pix("rst2", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    chk("rst2.stall", 32'(stall), 0);
    chk("rst2.ovf", 32'(ovf), 0);
    capture(1'b0, 32'h0D0C0B0A);
    for (int i = 0; i < 4; i++) begin
      chk_pix("post", 1'b1, row_c[i], 1'b0, 2'(i), 1'b0);
      tick();
    end
    chk("post.done", 32'(valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
